// File: rtl/mazesolver_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// mazesolver_jtag_scan_master
//
// Host-side JTAG scan initiator for the Nios II debug path. The block drives
// TCK/TMS/TDI into a virtual JTAG target with an IR_WIDTH-bit instruction
// register and walks the IEEE 1149.1 TAP controller. Each command can start
// with an IR scan. It always performs a DR scan, and it returns the DR bits
// captured from TDO.
//
// After reset the block brings the TAP to Test-Logic-Reset and then to
// Run-Test/Idle. Every scan starts and ends in Run-Test/Idle.
//
// Parameters
//   IR_WIDTH  instruction register length in bits
//   DR_WIDTH  data register length in bits
//   CLK_DIV   clk cycles per TCK half-period (>= 1)
//
// Ports
//   clk        system clock; all logic runs in this domain
//   reset      asynchronous, active-high reset
//   cmd_valid  command request
//   cmd_ready  high when idle and initialised; accept = cmd_valid && cmd_ready
//   cmd_ir_en  1 = perform an IR scan before the DR scan
//   cmd_ir     IR value, shifted LSB first
//   cmd_dr     DR value, shifted LSB first
//   rsp_valid  one-cycle pulse when the scan completes
//   rsp_dr     captured TDO bits, first bit sampled in bit 0; held until the
//              next rsp_valid
//   tck        JTAG clock
//   tms        JTAG mode select
//   tdi        JTAG data to the target
//   tdo        JTAG data from the target, synchronous to clk
// -----------------------------------------------------------------------------
module mazesolver_jtag_scan_master #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir_en,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  // Index of the final TCK cycle in each TMS sequence.
  //   INIT    : five cycles with TMS=1, then one with TMS=0
  //   IR scan : 1,1,0,0, IR_WIDTH shift cycles, 1, 0
  //   DR scan : 1,0,0, DR_WIDTH shift cycles, 1, 0
  localparam int INIT_LAST = 5;
  localparam int IR_LAST   = IR_WIDTH + 5;
  localparam int DR_LAST   = DR_WIDTH + 4;

  localparam int MAX_LAST  = (IR_LAST > DR_LAST) ? IR_LAST : DR_LAST;
  localparam int CNT_W     = $clog2(MAX_LAST + 1);
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] INIT_LAST_C = CNT_W'(INIT_LAST);
  localparam logic [CNT_W-1:0] IR_LAST_C   = CNT_W'(IR_LAST);
  localparam logic [CNT_W-1:0] DR_LAST_C   = CNT_W'(DR_LAST);
  localparam logic [DIV_W-1:0] DIV_LAST_C  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_IR_SCAN,
    S_DR_SCAN,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // TMS and shift-window lookup, keyed by the TCK cycle index within a
  // sequence.
  // ---------------------------------------------------------------------------
  function automatic logic ir_shift_at(input int idx);
    ir_shift_at = (idx >= 4) && (idx <= IR_WIDTH + 3);
  endfunction

  function automatic logic dr_shift_at(input int idx);
    dr_shift_at = (idx >= 3) && (idx <= DR_WIDTH + 2);
  endfunction

  // TMS=1 on Select-DR and Select-IR, on the last shift (to Exit1-IR), and
  // on Update-IR.
  function automatic logic ir_tms_at(input int idx);
    ir_tms_at = (idx <= 1) || (idx == IR_WIDTH + 3) || (idx == IR_WIDTH + 4);
  endfunction

  // TMS=1 on Select-DR, on the last shift (to Exit1-DR), and on Update-DR.
  function automatic logic dr_tms_at(input int idx);
    dr_tms_at = (idx == 0) || (idx == DR_WIDTH + 2) || (idx == DR_WIDTH + 3);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic                first_q;     // next edge opens the first low phase
  logic [DIV_W-1:0]    div_q;       // clk count within the current TCK phase
  logic [CNT_W-1:0]    cnt_q;       // TCK cycle index within the sequence
  logic                tck_q;
  logic                tms_q;
  logic                tdi_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] ir_sh_q;     // outgoing IR bits, LSB next
  logic [DR_WIDTH-1:0] dr_sh_q;     // outgoing DR bits in, captured TDO out

  // ---------------------------------------------------------------------------
  // Next-cycle decode
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             phase_end;
  logic             cur_ir_shift;
  logic             cur_dr_shift;
  logic             nxt_tms;
  logic             nxt_tdi;
  logic [CNT_W-1:0] last_cnt;
  int               cur_idx;
  int               nxt_idx;

  always_comb begin
    // NOTE: every signal driven here gets a default before the case so
    // no path can leave it unassigned and infer a latch.
    accept       = cmd_valid && cmd_ready_q;
    phase_end    = (div_q == DIV_LAST_C);
    cur_idx      = int'(cnt_q);
    nxt_idx      = first_q ? 0 : cur_idx + 1;
    last_cnt     = DR_LAST_C;
    cur_ir_shift = 1'b0;
    cur_dr_shift = 1'b0;
    nxt_tms      = 1'b0;
    nxt_tdi      = 1'b0;

    case (state_q)
      S_INIT: begin
        last_cnt = INIT_LAST_C;
        nxt_tms  = (nxt_idx < INIT_LAST);
      end
      S_IR_SCAN: begin
        last_cnt     = IR_LAST_C;
        nxt_tms      = ir_tms_at(nxt_idx);
        cur_ir_shift = ir_shift_at(cur_idx);
        if (ir_shift_at(nxt_idx)) nxt_tdi = ir_sh_q[0];
      end
      S_DR_SCAN: begin
        last_cnt     = DR_LAST_C;
        nxt_tms      = dr_tms_at(nxt_idx);
        cur_dr_shift = dr_shift_at(cur_idx);
        if (dr_shift_at(nxt_idx)) nxt_tdi = dr_sh_q[0];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer. The falling TCK edge advances the cycle index and presents the
  // new TMS/TDI. The rising edge samples TDO into the DR shift register, which
  // also drains the outgoing DR bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees the values from before the edge.
    if (reset) begin
      state_q     <= S_INIT;
      first_q     <= 1'b1;
      div_q       <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            ir_sh_q     <= cmd_ir;
            dr_sh_q     <= cmd_dr;
            first_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= cmd_ir_en ? S_IR_SCAN : S_DR_SCAN;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_INIT, S_IR_SCAN, S_DR_SCAN: begin
          if (first_q) begin
            // Opening edge of the first low phase: tck is already low.
            first_q <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            tms_q   <= nxt_tms;
            tdi_q   <= nxt_tdi;
          end else if (!phase_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!tck_q) begin
              tck_q <= 1'b1;
              // IR capture data is discarded; zeros are shifted in behind.
              if (cur_ir_shift) ir_sh_q <= ir_sh_q >> 1;
              if (cur_dr_shift) dr_sh_q <= DR_WIDTH'({tdo, dr_sh_q} >> 1);
            end else begin
              tck_q <= 1'b0;
              if (cnt_q == last_cnt) begin
                case (state_q)
                  S_INIT: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    tms_q       <= 1'b0;
                    tdi_q       <= 1'b0;
                  end
                  S_IR_SCAN: begin
                    // The DR sequence continues without a gap: this falling
                    // edge already opens its first low phase (Select-DR).
                    state_q <= S_DR_SCAN;
                    cnt_q   <= '0;
                    tms_q   <= 1'b1;
                    tdi_q   <= 1'b0;
                  end
                  default: begin
                    state_q     <= S_DONE;
                    rsp_dr_q    <= dr_sh_q;
                    rsp_valid_q <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    tms_q       <= 1'b0;
                    tdi_q       <= 1'b0;
                  end
                endcase
              end else begin
                cnt_q <= cnt_q + 1'b1;
                tms_q <= nxt_tms;
                tdi_q <= nxt_tdi;
              end
            end
          end
        end

        default: state_q <= S_INIT;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dr    = rsp_dr_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_mazesolver_jtag_scan_master.sv
// -----------------------------------------------------------------------------
// tb_mazesolver_jtag_scan_master
//
// Drives directed commands into the scan master. A behavioural 16-state TAP
// model with a 2-bit IR and a 38-bit DR answers on TDO. Expected responses
// are queued when each command is issued. A separate monitor pops the queue
// and compares on every rsp_valid.
// -----------------------------------------------------------------------------
module tb_mazesolver_jtag_scan_master;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int DIV = 4;
  localparam int LAT_IR_DR = 409;  // 1 + 51*2*4
  localparam int LAT_DR    = 345;  // 1 + 43*2*4

  logic           clk;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_ir_en;
  logic [IRW-1:0] cmd_ir;
  logic [DRW-1:0] cmd_dr;
  logic           rsp_valid;
  logic [DRW-1:0] rsp_dr;
  logic           tck;
  logic           tms;
  logic           tdi;
  logic           tdo = 1'b0;

  mazesolver_jtag_scan_master #(
    .IR_WIDTH (IRW),
    .DR_WIDTH (DRW),
    .CLK_DIV  (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir_en (cmd_ir_en),
    .cmd_ir    (cmd_ir),
    .cmd_dr    (cmd_dr),
    .rsp_valid (rsp_valid),
    .rsp_dr    (rsp_dr),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping and the check task
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // TAP model
  // ---------------------------------------------------------------------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     tap_next = m ? TLR    : RTI;
      RTI:     tap_next = m ? SEL_DR : RTI;
      SEL_DR:  tap_next = m ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = m ? EX1_DR : SH_DR;
      SH_DR:   tap_next = m ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = m ? UPD_DR : PA_DR;
      PA_DR:   tap_next = m ? EX2_DR : PA_DR;
      EX2_DR:  tap_next = m ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = m ? SEL_DR : RTI;
      SEL_IR:  tap_next = m ? TLR    : CAP_IR;
      CAP_IR:  tap_next = m ? EX1_IR : SH_IR;
      SH_IR:   tap_next = m ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = m ? UPD_IR : PA_IR;
      PA_IR:   tap_next = m ? EX2_IR : PA_IR;
      EX2_IR:  tap_next = m ? UPD_IR : SH_IR;
      default: tap_next = m ? SEL_DR : RTI;  // UPD_IR
    endcase
  endfunction

  tap_e           tap        = TLR;
  logic [DRW-1:0] dr_sr      = '0;
  logic [IRW-1:0] ir_sr      = '0;
  logic [DRW-1:0] dr_got     = '0;
  logic [IRW-1:0] ir_got     = '0;
  logic [DRW-1:0] cap_val    = '0;
  bit             loopback   = 1'b0;  // capture the last updated DR value
  bit             ir_visited = 1'b0;
  int             tck_rises  = 0;
  logic [15:0]    tms_hist   = '0;

  always @(posedge tck) begin
    tck_rises++;
    tms_hist = {tms_hist[14:0], tms};
    case (tap)
      CAP_DR: dr_sr = cap_val;
      SH_DR:  dr_sr = {tdi, dr_sr[DRW-1:1]};
      UPD_DR: begin
        dr_got = dr_sr;
        if (loopback) cap_val = dr_sr;
      end
      CAP_IR: ir_sr = 2'b01;
      SH_IR:  ir_sr = {tdi, ir_sr[IRW-1:1]};
      UPD_IR: ir_got = ir_sr;
      default: ;
    endcase
    tap = tap_next(tap, tms);
    if (tap >= SEL_IR) ir_visited = 1'b1;
  end

  always @(negedge tck) begin
    if (tap == SH_DR)      tdo = dr_sr[0];
    else if (tap == SH_IR) tdo = ir_sr[0];
    else                   tdo = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DRW-1:0] dr;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   rsp_log[$];
  int   cyc       = 0;
  int   rsp_count = 0;

  // Acceptance monitor: inputs are read before the edge's register updates.
  always @(posedge clk) begin
    cyc++;
    if (!reset && cmd_valid && cmd_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      exp_t e;
      int   lat;
      rsp_count++;
      rsp_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e   = exp_q.pop_front();
        lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        check("rsp_dr", 64'(rsp_dr), 64'(e.dr));
        check("rsp_latency", 64'(lat), 64'(e.lat));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic ir_en, input logic [IRW-1:0] ir,
                       input logic [DRW-1:0] dr, input bit hold);
    bit got;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir_en = ir_en;
    cmd_ir    = ir;
    cmd_dr    = dr;
    got       = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept", 64'(got), 64'd1);
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && rsp_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("rsp_arrived", 64'(rsp_count), 64'(target));
  endtask

  task automatic wait_init(input string tag);
    int ready_edge;
    ready_edge = 0;
    for (int e = 1; e <= 100 && ready_edge == 0; e++) begin
      @(posedge clk);
      #1;
      if (cmd_ready) ready_edge = e;
    end
    check({tag, "_ready_edge"}, 64'(ready_edge), 64'd49);
    check({tag, "_tck_rises"}, 64'(tck_rises), 64'd6);
    check({tag, "_tms_seq"}, 64'(tms_hist), 64'b111110);
    check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base_rises;
    int base_acc;
    int base_rsp;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir_en = 1'b0;
    cmd_ir    = '0;
    cmd_dr    = '0;
    #2 reset  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dr", 64'(rsp_dr), 64'd0);

    // INIT after reset release
    @(negedge clk);
    reset     = 1'b0;
    tck_rises = 0;
    tms_hist  = '0;
    wait_init("init");

    // IR + DR scan
    cap_val    = 38'h15_0F0F_F0F0;
    base_rises = tck_rises;
    exp_q.push_back('{dr: 38'h15_0F0F_F0F0, lat: LAT_IR_DR});
    issue(1'b1, 2'b01, 38'h2A_5555_AAAA, 1'b0);
    wait_rsp(1, 600);
    check("irdr_ir_got", 64'(ir_got), 64'h1);
    check("irdr_dr_got", 64'(dr_got), 64'h2A_5555_AAAA);
    check("irdr_tap_rti", 64'(tap), 64'(RTI));
    check("irdr_tck_rises", 64'(tck_rises - base_rises), 64'd51);

    // DR-only scan, target returns all ones
    cap_val    = 38'h3F_FFFF_FFFF;
    ir_visited = 1'b0;
    base_rises = tck_rises;
    exp_q.push_back('{dr: 38'h3F_FFFF_FFFF, lat: LAT_DR});
    issue(1'b0, 2'b00, 38'h0, 1'b0);
    wait_rsp(2, 600);
    check("dr_tck_rises", 64'(tck_rises - base_rises), 64'd43);
    check("dr_no_ir_states", 64'(ir_visited), 64'd0);
    check("dr_dr_got", 64'(dr_got), 64'h0);
    check("dr_tap_rti", 64'(tap), 64'(RTI));

    // Back-to-back with cmd_valid held: the target captures its last DR
    cap_val    = 38'h12_3456_789A;
    loopback   = 1'b1;
    base_rises = tck_rises;
    base_acc   = acc_log.size();
    base_rsp   = rsp_log.size();
    exp_q.push_back('{dr: 38'h12_3456_789A, lat: LAT_DR});
    exp_q.push_back('{dr: 38'h3A_BCDE_F012, lat: LAT_DR});
    issue(1'b0, 2'b00, 38'h3A_BCDE_F012, 1'b1);
    issue(1'b0, 2'b00, 38'h05_A5A5_1234, 1'b0);
    wait_rsp(4, 1200);
    loopback = 1'b0;
    check("b2b_accepts", 64'(acc_log.size() - base_acc), 64'd2);
    check("b2b_second_accept",
          64'((acc_log.size() >= base_acc + 2) ? acc_log[base_acc + 1] : -1),
          64'((rsp_log.size() > base_rsp) ? rsp_log[base_rsp] + 1 : -2));
    check("b2b_tck_rises", 64'(tck_rises - base_rises), 64'd86);
    check("b2b_dr_got", 64'(dr_got), 64'h05_A5A5_1234);

    // Busy: a pulse during the DR shift is ignored
    cap_val    = 38'h2B_0000_FFFF;
    ir_visited = 1'b0;
    base_rises = tck_rises;
    base_acc   = acc_log.size();
    exp_q.push_back('{dr: 38'h2B_0000_FFFF, lat: LAT_DR});
    issue(1'b0, 2'b00, 38'h11_2233_4455, 1'b0);
    repeat (100) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir_en = 1'b1;
    cmd_dr    = 38'h3F_0000_0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(5, 600);
    repeat (20) @(negedge clk);
    check("busy_accepts", 64'(acc_log.size() - base_acc), 64'd1);
    check("busy_tck_rises", 64'(tck_rises - base_rises), 64'd43);
    check("busy_dr_got", 64'(dr_got), 64'h11_2233_4455);
    check("busy_no_ir_states", 64'(ir_visited), 64'd0);
    check("busy_rsp_count", 64'(rsp_count), 64'd5);

    // Reset in the middle of DR bit 20 (the 24th TCK cycle of the scan)
    cap_val    = 38'h00_FFFF_0000;
    base_rises = tck_rises;
    base_rsp   = rsp_count;
    issue(1'b0, 2'b00, 38'h15_5555_5555, 1'b0);
    for (int i = 0; i < 1000 && (tck_rises - base_rises) < 24; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_reached_bit20", 64'(tck_rises - base_rises), 64'd24);
    check("mid_tck_high", 64'(tck), 64'd1);
    check("mid_tms_shift", 64'(tms), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tck", 64'(tck), 64'd0);
    check("mid_rst_tms", 64'(tms), 64'd1);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_dr", 64'(rsp_dr), 64'd0);
    // The command is dropped, so its pending acceptance is discarded as well.
    acc_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    tck_rises = 0;
    tms_hist  = '0;
    wait_init("reinit");
    check("mid_no_rsp", 64'(rsp_count), 64'(base_rsp));

    // Fresh command after recovery
    cap_val    = 38'h3C_3C3C_3C3C;
    base_rises = tck_rises;
    exp_q.push_back('{dr: 38'h3C_3C3C_3C3C, lat: LAT_IR_DR});
    issue(1'b1, 2'b10, 38'h00_DEAD_BEEF, 1'b0);
    wait_rsp(base_rsp + 1, 600);
    check("post_ir_got", 64'(ir_got), 64'h2);
    check("post_dr_got", 64'(dr_got), 64'h00_DEAD_BEEF);
    check("post_tck_rises", 64'(tck_rises - base_rises), 64'd51);
    check("post_tap_rti", 64'(tap), 64'(RTI));

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mazesolver_jtag_scan_master.md
# mazesolver_jtag_scan_master

Host-side JTAG scan initiator for the Nios II debug path in the maze-solver SoC. It drives TCK/TMS/TDI into a 2-bit-IR virtual JTAG target and walks the IEEE 1149.1 TAP state machine. For each command it optionally performs an IR scan, then a DR scan. It returns the DR bits captured from TDO. Bench and on-board test harnesses use it as the initiator for the debug module's TCK-domain shift register.

## Interface
- IR_WIDTH, 2, instruction register length in bits
- DR_WIDTH, 38, data register length in bits
- CLK_DIV, 4, clk cycles per TCK half-period (≥1)

Ports:
- clk  in  1  system clock; all logic is in this one domain
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and initialised; a command is accepted on a clk edge with cmd_valid&&cmd_ready
- cmd_ir_en  in  1  1 = IR scan before the DR scan
- cmd_ir  in  IR_WIDTH  IR value, shifted LSB first
- cmd_dr  in  DR_WIDTH  DR value, shifted LSB first
- rsp_valid  out  1  one-cycle pulse when the scan completes
- rsp_dr  out  DR_WIDTH  captured TDO bits; first bit sampled goes to bit 0; held until the next rsp_valid
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to target
- tdo  in  1  JTAG data from target, synchronous to clk

## Operation
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_dr=0.
- States: INIT, IDLE, IR_SCAN, DR_SCAN, DONE.
- INIT runs after reset deassertion: 5 TCK cycles with TMS=1 (Test-Logic-Reset), then 1 with TMS=0 (Run-Test/Idle). It then moves to IDLE.
- IDLE: cmd_ready=1, tms=0, tck=0. On acceptance, cmd_ir, cmd_dr and cmd_ir_en are latched. The next state is IR_SCAN if cmd_ir_en=1, else DR_SCAN.
- IR_SCAN TMS sequence, one bit per TCK cycle:
  - 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - Then IR_WIDTH shift cycles. TMS=0 except on the last shift, where TMS=1 (Exit1-IR).
  - Then 1 (Update-IR) and 0 (Run-Test/Idle).
  - Total: IR_WIDTH+6 TCK cycles. TDO captured during the IR scan is discarded.
- DR_SCAN TMS sequence:
  - 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - Then DR_WIDTH shift cycles, with TMS=1 on the last.
  - Then 1 (Update-DR) and 0 (Run-Test/Idle).
  - Total: DR_WIDTH+5 TCK cycles.
- TDI carries the latched data bit during shift cycles only; TDI=0 otherwise.
- DONE: rsp_dr is loaded and rsp_valid pulses for one cycle. cmd_ready rises in the same cycle, then the block returns to IDLE.
- cmd_valid while cmd_ready=0 is ignored. No queuing.
- If cmd_valid is held continuously, the next command is accepted on the first clk edge with cmd_ready=1, which is the DONE cycle.

## Timing
- Each TCK cycle is a low phase of CLK_DIV clks followed by a high phase of CLK_DIV clks.
- tms and tdi update on the clk edge that drives tck 1→0, or at the start of the low phase.
- tdo is sampled on the clk edge that drives tck 0→1.
- The first TCK low phase of a scan begins on the clk edge after acceptance.
- Latency from the acceptance edge to rsp_valid is 1 + N·2·CLK_DIV clks, where N is the total TCK cycles.
  - Defaults, with IR: N=51, latency 409.
  - Defaults, DR only: N=43, latency 345.
- INIT lasts 6·2·CLK_DIV clks (48 at default) from reset deassertion. cmd_ready rises on the next edge after that.
- Asynchronous reset at any point, including mid-shift: outputs go immediately to their reset values, the latched command is dropped, no rsp_valid is issued, and INIT reruns.
- The divider counter restarts at 0 at the start of every phase. The shift counter wraps only via a state change, never modulo.

## Test plan
- Reset release: count TCK edges while cmd_ready=0 → exactly 6 rising edges, TMS=1,1,1,1,1,0; cmd_ready=1 at clk 49 after reset deassert.
- IR+DR scan: cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA; TAP model preloaded with capture 38'h15_0F0F_F0F0. Required response:
  - Model receives IR 01 and DR 38'h2A_5555_AAAA.
  - rsp_dr=38'h15_0F0F_F0F0.
  - rsp_valid exactly 409 clks after acceptance.
  - Model ends in Run-Test/Idle.
- DR-only: cmd_ir_en=0, cmd_dr=0, TAP model returns all ones → 43 TCK cycles, no IR states visited, rsp_dr=38'h3F_FFFF_FFFF.
- Back-to-back: cmd_valid held high with two different DR values → second acceptance on the rsp_valid cycle of the first; both rsp_dr values correct; no extra TCK cycles between scans.
- Busy: pulse cmd_valid during a DR shift → ignored; TCK count and rsp_dr unchanged.
- Mid-shift reset: assert reset at DR bit 20 → tck=0, tms=1 within the same cycle; no rsp_valid; after release, full INIT then a fresh command completes correctly.
